// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyphs (active-high g..a)
// and the bit positions of each segment inside the 8-bit {dp,g,f,e,d,c,b,a} bus.
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam int SEG_A_BIT  = 0;
   localparam int SEG_B_BIT  = 1;
   localparam int SEG_C_BIT  = 2;
   localparam int SEG_D_BIT  = 3;
   localparam int SEG_E_BIT  = 4;
   localparam int SEG_F_BIT  = 5;
   localparam int SEG_G_BIT  = 6;
   localparam int SEG_DP_BIT = 7;

endpackage

// File: rtl/sseg_scan_driver_hex_to_sseg.sv
// Combinational hex nibble to active-high g..a segment pattern.
module hex_to_sseg
   import sseg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexes a packed hex value onto an N-digit seven-segment display, taking a
// fresh snapshot of the value only when the scan wraps so a refresh never tears.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     dig_en,
   input  logic                  blank_lz,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            sseg,
   output logic                  scan_end
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0]     PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]     LAST_IDX  = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_OFF    = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [7:0]        SSEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [PW-1:0]       presc;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] snap;
   logic [DIGITS-1:0]   dp_snap;
   logic                tick;
   logic                wrap;
   logic [DIGITS-1:0]   leading_zero;
   logic [3:0]          cur_digit;
   logic [6:0]          cur_seg;
   logic                lit;
   logic [DIGITS-1:0]   an_act;
   logic [7:0]          sseg_act;
   logic [DIGITS-1:0]   an_next;
   logic [7:0]          sseg_next;

   assign tick = (presc == PRESC_MAX);
   assign wrap = tick && (idx == LAST_IDX);

   // Scan timing plus the snapshot, which only moves on the wrap edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc   <= '0;
         idx     <= '0;
         snap    <= value;
         dp_snap <= dp_in;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
         end
         if (wrap) begin
            snap    <= value;
            dp_snap <= dp_in;
         end
      end
   end

   // A digit is a leading zero when it and every digit above it are zero; digit 0 is
   // excluded so an all-zero value still shows a single "0".
   always_comb begin
      logic zero_run;
      leading_zero = '0;
      zero_run     = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run        = zero_run && (snap[4*i +: 4] == 4'h0);
         leading_zero[i] = zero_run;
      end
   end

   assign cur_digit = snap[{idx, 2'b00} +: 4];

   hex_to_sseg u_hex_to_sseg (
      .hex (cur_digit),
      .seg (cur_seg)
   );

   assign lit       = dig_en[idx] && !(blank_lz && leading_zero[idx]);
   assign an_act    = lit ? (DIGITS'(1) << idx) : '0;
   assign sseg_act  = lit ? {dp_snap[idx], cur_seg} : 8'h00;
   assign an_next   = ACTIVE_LOW ? ~an_act   : an_act;
   assign sseg_next = ACTIVE_LOW ? ~sseg_act : sseg_act;

   // Anodes and segments share one register stage so they always switch together.
   always_ff @(posedge clk) begin
      if (reset) begin
         an       <= AN_OFF;
         sseg     <= SSEG_OFF;
         scan_end <= 1'b0;
      end else begin
         an       <= an_next;
         sseg     <= sseg_next;
         scan_end <= wrap;
      end
   end

endmodule
